burst_write_master: RTL and testbench
=====================================

# burst_write_master

Parametrised Avalon-MM burst write master that drains a user-side FIFO into memory (SDRAM through the softproc interconnect). It is the next-generation user-logic write master: configurable data width, FIFO depth and maximum burst length, and it keeps fixed-location (streaming into one register) and incrementing-address modes. User logic pushes words, programs base and length, pulses go, and waits for done.

## Interface
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDRESS_WIDTH, 32, byte address width.
- LENGTH_WIDTH, 32, transfer length width in bytes.
- FIFO_DEPTH, 32, FIFO entries; power of 2, >= MAX_BURST.
- MAX_BURST, 8, maximum burstcount; power of 2, >= 1.
- clk_clk  in  1  sole clock; all logic on rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- control_fixed_location  in  1  1 = every burst to write_base; sampled at go.
- control_write_base  in  ADDRESS_WIDTH  start byte address; sampled at go.
- control_write_length  in  LENGTH_WIDTH  bytes to write; sampled at go.
- control_go  in  1  start pulse.
- control_done  out  1  transfer complete (level).
- user_write_buffer  in  1  push strobe.
- user_buffer_input_data  in  DATA_WIDTH  push data.
- user_buffer_full  out  1  FIFO full.
- master_address  out  ADDRESS_WIDTH  burst start byte address.
- master_write  out  1  write request.
- master_byteenable  out  DATA_WIDTH/8  always all ones.
- master_writedata  out  DATA_WIDTH  FIFO head.
- master_burstcount  out  clog2(MAX_BURST)+1  beats in current burst.
- master_waitrequest  in  1  slave stall.

## Operation
- BPW = DATA_WIDTH/8. Word count = write_length / BPW; low log2(BPW) length bits ignored; base assumed word-aligned, low bits forced to zero.
- States: IDLE, WAIT_DATA, BURST.
- IDLE: go=1 latches base, word count, fixed_location; clears control_done. Word count 0 -> stays IDLE, control_done=1 next cycle, no writes. Otherwise -> WAIT_DATA.
- go outside IDLE ignored; latched values unchanged.
- WAIT_DATA: burst size B = min(MAX_BURST, remaining words). When FIFO count >= B: drive address/burstcount=B, -> BURST.
- BURST: master_write=1 every cycle; beat accepted when master_waitrequest=0, pops FIFO, decrements beat and remaining counters. Address and burstcount held constant whole burst. After last beat: remaining 0 -> IDLE with control_done=1; else address += B*BPW (unchanged if fixed_location), -> WAIT_DATA.
- Address arithmetic wraps modulo 2^ADDRESS_WIDTH.
- FIFO: push accepted iff user_write_buffer=1 and not full; push while full is rejected even if a pop occurs that cycle. Simultaneous push and pop when not full: count unchanged. Pushes accepted in any state, including IDLE (prefill).
- user_buffer_full = (count == FIFO_DEPTH), registered.
- Words pushed beyond the programmed length remain in FIFO for the next transfer.
- Reset values: control_done 0, user_buffer_full 0, master_write 0, master_address 0, master_burstcount 0, FIFO empty, state IDLE. Reset mid-burst abandons the burst immediately.

## Timing
- go at cycle N -> WAIT_DATA at N+1; if FIFO already holds B words, master_write rises at N+2.
- Pushed word counts toward the FIFO threshold from the cycle after the push.
- Within a burst no bubbles: master_write stays high until the last beat is accepted.
- One idle cycle between consecutive bursts (the WAIT_DATA evaluation).
- control_done rises the cycle after the final beat is accepted; held until next accepted go.
- user_buffer_full updates the cycle after the push/pop that changes it.

## Configuration
- BURST_WRITE_MASTER_OVERFLOW_EN defined: extra output user_buffer_overflow (1 bit, reset 0), set sticky by any push rejected while full, cleared by an accepted go.
- Not defined: port absent; rejected pushes silently dropped.

## Test plan
- Prefill 16 words 0..15, base 0x1000, length 64, MAX_BURST 8 -> two bursts of 8 at 0x1000 and 0x1020, data 0..15 in order, done one cycle after last beat.
- Length 40 (10 words), data trickled one word every 3 cycles -> bursts 8 then 2, second at 0x1020; no master_write before threshold met.
- fixed_location=1, length 32 -> both... single burst of 8 at base; with MAX_BURST 4, two bursts both at base.
- master_waitrequest toggled randomly during burst -> address/burstcount stable, each word written exactly once, no loss.
- FIFO filled to 32, push held -> full=1, extra pushes rejected; with BURST_WRITE_MASTER_OVERFLOW_EN overflow=1 until next go.
- Length 0 -> done next cycle, no writes; reset_reset_n pulsed mid-burst -> all outputs to reset values, FIFO empty.

Source files
------------

// File: rtl/burst_write_master_if.sv
// Bus bundle for burst_write_master: control, user FIFO and Avalon-MM write master signals.
// user_buffer_overflow exists only when BURST_WRITE_MASTER_OVERFLOW_EN is defined.
interface burst_write_master_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int LENGTH_WIDTH  = 32,
  parameter int MAX_BURST     = 8
);
  localparam int BCW = $clog2(MAX_BURST) + 1;

  logic                      control_fixed_location;
  logic [ADDRESS_WIDTH-1:0]  control_write_base;
  logic [LENGTH_WIDTH-1:0]   control_write_length;
  logic                      control_go;
  logic                      control_done;
  logic                      user_write_buffer;
  logic [DATA_WIDTH-1:0]     user_buffer_input_data;
  logic                      user_buffer_full;
`ifdef BURST_WRITE_MASTER_OVERFLOW_EN
  logic                      user_buffer_overflow;
`endif
  logic [ADDRESS_WIDTH-1:0]  master_address;
  logic                      master_write;
  logic [DATA_WIDTH/8-1:0]   master_byteenable;
  logic [DATA_WIDTH-1:0]     master_writedata;
  logic [BCW-1:0]            master_burstcount;
  logic                      master_waitrequest;

  modport master (
`ifdef BURST_WRITE_MASTER_OVERFLOW_EN
    output user_buffer_overflow,
`endif
    input  control_fixed_location, control_write_base, control_write_length, control_go,
    output control_done,
    input  user_write_buffer, user_buffer_input_data,
    output user_buffer_full,
    output master_address, master_write, master_byteenable, master_writedata, master_burstcount,
    input  master_waitrequest
  );

  modport slave (
`ifdef BURST_WRITE_MASTER_OVERFLOW_EN
    input  user_buffer_overflow,
`endif
    output control_fixed_location, control_write_base, control_write_length, control_go,
    input  control_done,
    output user_write_buffer, user_buffer_input_data,
    input  user_buffer_full,
    input  master_address, master_write, master_byteenable, master_writedata, master_burstcount,
    output master_waitrequest
  );
endinterface

// File: rtl/burst_write_master.sv
// Avalon-MM burst write master draining a user FIFO to memory (fixed or incrementing address).
// Optional sticky overflow flag enabled by defining BURST_WRITE_MASTER_OVERFLOW_EN.
module burst_write_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int LENGTH_WIDTH  = 32,
  parameter int FIFO_DEPTH    = 32,
  parameter int MAX_BURST     = 8
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  burst_write_master_if.master bus
);
  localparam int BPW   = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BPW);
  localparam int BCW   = $clog2(MAX_BURST) + 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_BURST     = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0]  mst_addr_q, mst_addr_d;
  logic [LENGTH_WIDTH-1:0]   remain_q, remain_d;
  logic                      fixed_q, fixed_d;
  logic [BCW-1:0]            bcount_q, bcount_d;
  logic [BCW-1:0]            beats_q, beats_d;
  logic                      write_q, write_d;
  logic                      done_q, done_d;

  logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]             wptr_q, wptr_d;
  logic [PW-1:0]             rptr_q, rptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      full_q, full_d;

  logic                      push_s, pop_s, go_s;
  logic [BCW-1:0]            burst_len_s;
  logic [LENGTH_WIDTH-1:0]   words_s;

  assign push_s  = bus.user_write_buffer & ~full_q;
  assign pop_s   = (state_q == ST_BURST) & ~bus.master_waitrequest;
  assign go_s    = bus.control_go & (state_q == ST_IDLE);
  assign words_s = bus.control_write_length >> SHIFT;
  assign burst_len_s = (remain_q >= LENGTH_WIDTH'(MAX_BURST)) ? BCW'(MAX_BURST) : BCW'(remain_q);

  // FIFO pointer and occupancy next-state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_s) begin
      wptr_d = wptr_q + PW'(1'b1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1'b1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(FIFO_DEPTH));
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk_clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= bus.user_buffer_input_data;
    end
  end

  // FIFO control registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Transfer FSM next-state and registered-output next values
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mst_addr_d = mst_addr_q;
    remain_d   = remain_q;
    fixed_d    = fixed_q;
    bcount_d   = bcount_q;
    beats_d    = beats_q;
    write_d    = write_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          addr_d   = bus.control_write_base & ~(ADDRESS_WIDTH'(BPW - 1));
          remain_d = words_s;
          fixed_d  = bus.control_fixed_location;
          if (words_s == {LENGTH_WIDTH{1'b0}}) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            done_d  = 1'b0;
            state_d = ST_WAIT_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DATA: begin
        if (count_q >= CW'(burst_len_s)) begin
          mst_addr_d = addr_q;
          bcount_d   = burst_len_s;
          beats_d    = burst_len_s;
          write_d    = 1'b1;
          state_d    = ST_BURST;
        end else begin
          state_d = ST_WAIT_DATA;
        end
      end
      ST_BURST: begin
        if (!bus.master_waitrequest) begin
          beats_d  = beats_q - BCW'(1'b1);
          remain_d = remain_q - LENGTH_WIDTH'(1'b1);
          if (beats_q == BCW'(1'b1)) begin
            write_d = 1'b0;
            if (remain_q == LENGTH_WIDTH'(1'b1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_WAIT_DATA;
              if (fixed_q) begin
                addr_d = addr_q;
              end else begin
                addr_d = addr_q + (ADDRESS_WIDTH'(bcount_q) << SHIFT);
              end
            end
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
      end
    endcase
  end

  // Transfer FSM state and output registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= {ADDRESS_WIDTH{1'b0}};
      mst_addr_q <= {ADDRESS_WIDTH{1'b0}};
      remain_q   <= {LENGTH_WIDTH{1'b0}};
      fixed_q    <= 1'b0;
      bcount_q   <= {BCW{1'b0}};
      beats_q    <= {BCW{1'b0}};
      write_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mst_addr_q <= mst_addr_d;
      remain_q   <= remain_d;
      fixed_q    <= fixed_d;
      bcount_q   <= bcount_d;
      beats_q    <= beats_d;
      write_q    <= write_d;
      done_q     <= done_d;
    end
  end

`ifdef BURST_WRITE_MASTER_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a rejected push wins over a same-cycle go
  always_comb begin
    if (bus.user_write_buffer && full_q) begin
      ovf_d = 1'b1;
    end else if (go_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.user_buffer_overflow = ovf_q;
`endif

  assign bus.control_done      = done_q;
  assign bus.user_buffer_full  = full_q;
  assign bus.master_address    = mst_addr_q;
  assign bus.master_write      = write_q;
  assign bus.master_byteenable = {(DATA_WIDTH/8){1'b1}};
  assign bus.master_writedata  = mem_q[rptr_q];
  assign bus.master_burstcount = bcount_q;
endmodule

// File: tb/tb_burst_write_master.sv
// Directed + randomized bench for burst_write_master with a queue-based reference model.
module tb_burst_write_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  burst_write_master_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .LENGTH_WIDTH(32), .MAX_BURST(8)) bus ();

  burst_write_master #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .LENGTH_WIDTH(32),
                       .FIFO_DEPTH(32), .MAX_BURST(8)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    bit ok;
    ok = (mq.size() < 32);
    bus.user_write_buffer = 1'b1;
    bus.user_buffer_input_data = d;
    tick();
    bus.user_write_buffer = 1'b0;
    if (ok) mq.push_back(d);
  endtask

  // One transfer: go, then per-cycle model of bursts, data order, done and gaps
  task automatic run_xfer(input logic [31:0] base, input logic [31:0] len, input bit fixed,
                          input int period, input bit wr_rand, input int exp_first);
    logic [31:0] cur, pdata;
    int words, rem, need, b, beat, first;
    bit push_ok, pop, fin;
    words = int'(len >> 2);
    cur = base & 32'hFFFF_FFFC;
    rem = words;
    need = (words > mq.size()) ? words - mq.size() : 0;
    bus.control_write_base = base;
    bus.control_write_length = len;
    bus.control_fixed_location = fixed;
    bus.control_go = 1'b1;
    tick();
    bus.control_go = 1'b0;
    chk("done_after_go", bus.control_done, (words == 0) ? 1 : 0);
`ifdef BURST_WRITE_MASTER_OVERFLOW_EN
    chk("ovf_cleared_by_go", bus.user_buffer_overflow, 0);
`endif
    if (words == 0) begin
      for (int k = 0; k < 4; k++) begin
        chk("len0_no_write", bus.master_write, 0);
        chk("len0_done", bus.control_done, 1);
        tick();
      end
      return;
    end
    beat = 0; first = -1; fin = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      b = (rem < 8) ? rem : 8;
      push_ok = 1'b0;
      pop = 1'b0;
      pdata = $urandom;
      bus.user_write_buffer = 1'b0;
      if (need > 0 && (cyc % period) == 0) begin
        bus.user_write_buffer = 1'b1;
        bus.user_buffer_input_data = pdata;
        push_ok = (mq.size() < 32);
      end
      bus.master_waitrequest = wr_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
      chk("done_low_busy", bus.control_done, 0);
      if (bus.master_write) begin
        if (first < 0) first = cyc;
        if (beat == 0) chk("threshold_met", (mq.size() >= b) ? 1 : 0, 1);
        chk("address", bus.master_address, cur);
        chk("burstcount", bus.master_burstcount, b);
        chk("byteenable", bus.master_byteenable, 4'hF);
        if (!bus.master_waitrequest) begin
          if (mq.size() > 0) chk("writedata", bus.master_writedata, mq[0]);
          else chk("write_with_empty_model", mq.size(), 1);
          pop = 1'b1;
        end
      end else begin
        chk("no_bubble", beat, 0);
      end
      tick();
      if (pop) begin
        if (mq.size() > 0) void'(mq.pop_front());
        beat++;
      end
      if (push_ok) begin
        mq.push_back(pdata);
        need--;
      end
      bus.user_write_buffer = 1'b0;
      if (pop && beat == b) begin
        beat = 0;
        rem -= b;
        if (!fixed) cur = cur + 32'(b * 4);
        if (rem == 0) begin
          chk("done_rise", bus.control_done, 1);
          chk("write_drop", bus.master_write, 0);
          fin = 1'b1;
        end else begin
          chk("inter_burst_gap", bus.master_write, 0);
        end
      end
    end
    bus.master_waitrequest = 1'b0;
    chk("xfer_timeout", fin, 1);
    if (exp_first >= 0) chk("first_write_latency", first, exp_first);
  endtask

  initial begin
    bus.control_fixed_location = 1'b0;
    bus.control_write_base = 32'h0;
    bus.control_write_length = 32'h0;
    bus.control_go = 1'b0;
    bus.user_write_buffer = 1'b0;
    bus.user_buffer_input_data = 32'h0;
    bus.master_waitrequest = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_done", bus.control_done, 0);
    chk("rst_full", bus.user_buffer_full, 0);
    chk("rst_write", bus.master_write, 0);
    chk("rst_address", bus.master_address, 0);
    chk("rst_burstcount", bus.master_burstcount, 0);

    // prefill 0..15, two bursts at 0x1000 / 0x1020
    for (int i = 0; i < 16; i++) push_word(32'(i));
    run_xfer(32'h1000, 32'd64, 1'b0, 1, 1'b0, 1);
    tick(); tick();
    chk("done_held", bus.control_done, 1);

    // trickled data, 10 words
    run_xfer(32'h1000, 32'd40, 1'b0, 3, 1'b0, -1);

    // fixed location
    for (int i = 0; i < 8; i++) push_word($urandom);
    run_xfer(32'h2000, 32'd32, 1'b1, 1, 1'b0, 1);
    run_xfer(32'h2004, 32'd64, 1'b1, 2, 1'b1, -1);

    // leftover words stay for the next transfer; unaligned length/base
    for (int i = 0; i < 12; i++) push_word($urandom);
    run_xfer(32'h2103, 32'd35, 1'b0, 1, 1'b1, -1);
    run_xfer(32'h2200, 32'd16, 1'b0, 1, 1'b1, -1);

    // zero-word lengths
    run_xfer(32'h3000, 32'd0, 1'b0, 1, 1'b0, -1);
    run_xfer(32'h3000, 32'd3, 1'b0, 1, 1'b0, -1);

    // address wrap and random transfers with random waitrequest
    run_xfer(32'hFFFF_FFF0, 32'd64, 1'b0, 1, 1'b1, -1);
    for (int i = 0; i < 6; i++)
      run_xfer($urandom, 32'($urandom_range(4, 160)), 1'($urandom_range(0, 1)),
               $urandom_range(1, 4), 1'b1, -1);

    // fill to full, then reject extra pushes
    while (mq.size() < 31) push_word($urandom);
    chk("full_at_31", bus.user_buffer_full, 0);
    push_word($urandom);
    chk("full_at_32", bus.user_buffer_full, 1);
    for (int i = 0; i < 3; i++) push_word($urandom);
    chk("full_held", bus.user_buffer_full, 1);
`ifdef BURST_WRITE_MASTER_OVERFLOW_EN
    chk("overflow_set", bus.user_buffer_overflow, 1);
`endif
    run_xfer(32'h4000, 32'd128, 1'b0, 1, 1'b1, -1);
    chk("full_cleared", bus.user_buffer_full, 0);

    // reset mid-burst
    for (int i = 0; i < 8; i++) push_word($urandom);
    bus.control_write_base = 32'h5000;
    bus.control_write_length = 32'd32;
    bus.control_fixed_location = 1'b0;
    bus.control_go = 1'b1;
    tick();
    bus.control_go = 1'b0;
    bus.master_waitrequest = 1'b0;
    for (int k = 0; k < 10 && !bus.master_write; k++) tick();
    tick(); tick();
    chk("pre_rst_write", bus.master_write, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_write", bus.master_write, 0);
    chk("midrst_address", bus.master_address, 0);
    chk("midrst_burstcount", bus.master_burstcount, 0);
    chk("midrst_done", bus.control_done, 0);
    chk("midrst_full", bus.user_buffer_full, 0);
    mq.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_write", bus.master_write, 0);
    run_xfer(32'h6000, 32'd32, 1'b0, 1, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
